// File: rtl/axi4_lite_master_cmd_if.sv
// AXI4-Lite channel bundle between the command-driven master and one register-file slave.
interface axi4_lite_master_cmd_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI read or write out, one response back.
// A per-transaction timeout frees the requester from a slave that never answers.
module axi4_lite_master_cmd #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  axi4_lite_master_cmd_if.master          m_axi
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WR_B = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_RD_R = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic aw_done, w_done, timed_out, active, fire_timeout;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    fire_timeout  = 1'b0;

    // A channel counts as done once its VALID has dropped or is handshaking right now.
    aw_done   = !awvalid_q || m_axi.awready;
    w_done    = !wvalid_q  || m_axi.wready;
    active    = (state_q == S_WR) || (state_q == S_WR_B) ||
                (state_q == S_RD) || (state_q == S_RD_R);
    timed_out = TO_EN && active && (cnt_q == TO_LIMIT);

    if (active && (cnt_q != TO_LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = '0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD;
          end
        end
      end
      S_WR: begin
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end else if (timed_out) begin
          fire_timeout = 1'b1;
        end
      end
      S_WR_B: begin
        if (m_axi.bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi.bresp;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (timed_out) begin
          fire_timeout = 1'b1;
        end
      end
      S_RD: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end else if (timed_out) begin
          fire_timeout = 1'b1;
        end
      end
      S_RD_R: begin
        if (m_axi.rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axi.rdata;
          rsp_resp_d    = m_axi.rresp;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (timed_out) begin
          fire_timeout = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abandon the bus; any late B/R beat is ignored because the READYs are low.
    if (fire_timeout) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      state_d       = S_RESP;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      // NOTE: datapath registers are reset as well so the bus never shows X after reset.
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign busy          = (state_q != S_IDLE);

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
// Directed bench for axi4_lite_master_cmd: a vector table of whole transactions against a
// scripted slave, plus hand-written latency, back-pressure, timeout and reset sequences.
module tb_axi4_lite_master_cmd;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        busy;

  axi4_lite_master_cmd_if #(.DW(32), .AW(32)) m_axi ();

  axi4_lite_master_cmd #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .m_axi        (m_axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slave latencies are in cycles after VALID/READY is first seen; -1 means the slave never answers.
  typedef struct {
    string       name;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          a_lat;
    int          w_lat;
    int          d_lat;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    bit          e_timeout;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic slave_aw(input vec_t v);
    int n = 0;
    while (m_axi.awvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (m_axi.awvalid !== 1'b1) begin fail_now({v.name, ".aw_wait"}); return; end
    repeat (v.a_lat) @(negedge clk);
    check({v.name, ".awvalid_hold"}, {31'd0, m_axi.awvalid}, 32'd1);
    check({v.name, ".awaddr"}, m_axi.awaddr, v.addr);
    check({v.name, ".awprot"}, {29'd0, m_axi.awprot}, 32'd0);
    m_axi.awready = 1'b1;
    @(negedge clk);
    m_axi.awready = 1'b0;
    check({v.name, ".awvalid_drop"}, {31'd0, m_axi.awvalid}, 32'd0);
  endtask

  task automatic slave_w(input vec_t v);
    int n = 0;
    while (m_axi.wvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (m_axi.wvalid !== 1'b1) begin fail_now({v.name, ".w_wait"}); return; end
    repeat (v.w_lat) @(negedge clk);
    check({v.name, ".wvalid_hold"}, {31'd0, m_axi.wvalid}, 32'd1);
    check({v.name, ".wdata"}, m_axi.wdata, v.wdata);
    check({v.name, ".wstrb"}, {28'd0, m_axi.wstrb}, {28'd0, v.wstrb});
    m_axi.wready = 1'b1;
    @(negedge clk);
    m_axi.wready = 1'b0;
    check({v.name, ".wvalid_drop"}, {31'd0, m_axi.wvalid}, 32'd0);
  endtask

  task automatic slave_b(input vec_t v);
    int n = 0;
    while (m_axi.bready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (m_axi.bready !== 1'b1) begin fail_now({v.name, ".b_wait"}); return; end
    repeat (v.d_lat) @(negedge clk);
    m_axi.bvalid = 1'b1;
    m_axi.bresp  = v.s_resp;
    @(negedge clk);
    m_axi.bvalid = 1'b0;
    m_axi.bresp  = 2'b00;
    check({v.name, ".bready_drop"}, {31'd0, m_axi.bready}, 32'd0);
  endtask

  task automatic slave_ar(input vec_t v);
    int n = 0;
    while (m_axi.arvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (m_axi.arvalid !== 1'b1) begin fail_now({v.name, ".ar_wait"}); return; end
    repeat (v.a_lat) @(negedge clk);
    check({v.name, ".arvalid_hold"}, {31'd0, m_axi.arvalid}, 32'd1);
    check({v.name, ".araddr"}, m_axi.araddr, v.addr);
    check({v.name, ".arprot"}, {29'd0, m_axi.arprot}, 32'd0);
    m_axi.arready = 1'b1;
    @(negedge clk);
    m_axi.arready = 1'b0;
    check({v.name, ".arvalid_drop"}, {31'd0, m_axi.arvalid}, 32'd0);
  endtask

  task automatic slave_r(input vec_t v);
    int n = 0;
    while (m_axi.rready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (m_axi.rready !== 1'b1) begin fail_now({v.name, ".r_wait"}); return; end
    repeat (v.d_lat) @(negedge clk);
    m_axi.rvalid = 1'b1;
    m_axi.rdata  = v.s_rdata;
    m_axi.rresp  = v.s_resp;
    @(negedge clk);
    m_axi.rvalid = 1'b0;
    m_axi.rdata  = 32'd0;
    m_axi.rresp  = 2'b00;
    check({v.name, ".rready_drop"}, {31'd0, m_axi.rready}, 32'd0);
  endtask

  task automatic wait_cmd_ready(input string name);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) fail_now({name, ".cmd_ready_wait"});
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    fork
      begin
        int n = 0;
        wait_cmd_ready(v.name);
        issue(v.write, v.addr, v.wdata, v.wstrb);
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (rsp_valid !== 1'b1) begin
          fail_now({v.name, ".rsp_wait"});
        end else begin
          check({v.name, ".rsp_resp"}, {30'd0, rsp_resp}, {30'd0, v.e_resp});
          check({v.name, ".rsp_rdata"}, rsp_rdata, v.e_rdata);
          check({v.name, ".rsp_timeout"}, {31'd0, rsp_timeout}, {31'd0, v.e_timeout});
          rsp_ready = 1'b1;
          @(negedge clk);
          rsp_ready = 1'b0;
        end
      end
      begin
        if (v.a_lat >= 0) begin
          if (v.write) begin
            fork
              slave_aw(v);
              slave_w(v);
            join
            if (v.d_lat >= 0) slave_b(v);
          end else begin
            slave_ar(v);
            if (v.d_lat >= 0) slave_r(v);
          end
        end
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] held;

    vecs[0] = '{"wr_aw_late",  1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF,  1,  0,  0, 2'b00, 32'h0,         2'b00, 32'h0,         1'b0};
    vecs[1] = '{"rd_3wait",    1'b0, 32'h0000_0008, 32'h0,         4'h0,  0,  0,  3, 2'b00, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{"wr_bresp_11", 1'b1, 32'h0000_0100, 32'h0102_0304, 4'h3,  0,  0,  1, 2'b11, 32'h0,         2'b11, 32'h0,         1'b0};
    vecs[3] = '{"wr_w_late",   1'b1, 32'h0000_0ABC, 32'h55AA_55AA, 4'h5,  0,  2,  0, 2'b00, 32'h0,         2'b00, 32'h0,         1'b0};
    vecs[4] = '{"rd_rresp_10", 1'b0, 32'h0000_0040, 32'h0,         4'h0,  2,  0,  0, 2'b10, 32'h1234_5678, 2'b10, 32'h1234_5678, 1'b0};
    vecs[5] = '{"rd_hang_ar",  1'b0, 32'h0000_0044, 32'h0,         4'h0, -1,  0, -1, 2'b00, 32'h0,         2'b10, 32'h0,         1'b1};
    vecs[6] = '{"rd_after_to", 1'b0, 32'h0000_0048, 32'h0,         4'h0,  0,  0,  0, 2'b00, 32'h600D_F00D, 2'b00, 32'h600D_F00D, 1'b0};
    vecs[7] = '{"wr_hang_b",   1'b1, 32'h0000_004C, 32'hFFFF_0000, 4'hC,  0,  0, -1, 2'b00, 32'h0,         2'b10, 32'h0,         1'b1};
    vecs[8] = '{"wr_slverr",   1'b1, 32'h0000_0050, 32'hA5A5_5A5A, 4'hF,  3,  3,  2, 2'b10, 32'h0,         2'b10, 32'h0,         1'b0};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    m_axi.awready = 1'b0; m_axi.wready = 1'b0;
    m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
    m_axi.arready = 1'b0;
    m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = 2'b00;

    // Reset state and cmd_ready timing after release.
    repeat (3) @(negedge clk);
    check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.valids", {27'd0, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 32'd0);
    rst_n = 1'b1;
    #1 check("rel.cmd_ready_first", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("rel.cmd_ready_next", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Zero-wait read latency, then response back-pressure for 10 cycles.
    wait_cmd_ready("lat");
    m_axi.arready = 1'b1;
    m_axi.rvalid  = 1'b1;
    m_axi.rdata   = 32'hCAFE_F00D;
    m_axi.rresp   = 2'b00;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    check("lat.c1_arvalid", {31'd0, m_axi.arvalid}, 32'd1);
    check("lat.c1_araddr", m_axi.araddr, 32'h0000_0020);
    check("lat.c1_busy", {31'd0, busy}, 32'd1);
    check("lat.c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    m_axi.arready = 1'b0;
    check("lat.c2_arvalid", {31'd0, m_axi.arvalid}, 32'd0);
    check("lat.c2_rready", {31'd0, m_axi.rready}, 32'd1);
    @(negedge clk);
    m_axi.rvalid = 1'b0;
    m_axi.rdata  = 32'd0;
    check("lat.c3_rready", {31'd0, m_axi.rready}, 32'd0);
    check("lat.c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("lat.c3_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    held = rsp_rdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall.rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      check("stall.cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("stall.axi_idle", {27'd0, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall.rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("stall.cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    check("stall.busy_drop", {31'd0, busy}, 32'd0);

    // Hung AR: counter is 0 in cycle 1 and reaches 16 in cycle 17, so ARVALID is high for cycles 1..17.
    wait_cmd_ready("to");
    issue(1'b0, 32'h0000_0060, 32'h0, 4'h0);
    n = 0;
    while (m_axi.arvalid === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("to.arvalid_cycles", n, TO + 1);
    check("to.rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to.rsp_resp", {30'd0, rsp_resp}, 32'd2);
    check("to.rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    check("to.rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    run_vec(vecs[6]);

    // Reset while AWVALID is high: outputs drop at once and no response follows.
    wait_cmd_ready("rst_mid");
    issue(1'b1, 32'h0000_0070, 32'h1111_2222, 4'hF);
    check("rst_mid.awvalid_before", {31'd0, m_axi.awvalid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.awvalid", {31'd0, m_axi.awvalid}, 32'd0);
    check("rst_mid.wvalid", {31'd0, m_axi.wvalid}, 32'd0);
    check("rst_mid.busy", {31'd0, busy}, 32'd0);
    check("rst_mid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_mid.cmd_ready_first", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("rst_mid.cmd_ready_next", {31'd0, cmd_ready}, 32'd1);
    check("rst_mid.no_rsp", {31'd0, rsp_valid}, 32'd0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
